stack_ptr_guarded: RTL and testbench

Parametrised, bounds-checked stack pointer for the RAT MCU and its wider-datapath variants. It keeps the current top-of-stack address and supports load, increment and decrement. It also provides a configurable legal address window, with either wrap or saturate behaviour at the window edges. Sticky overflow/underflow/bad-load flags and a one-deep shadow register let the interrupt entry/return sequence save and restore the pointer. It sits beside the register file and scratch RAM and is driven by the control unit's SP_LD / SP_INCR / SP_DECR strobes.

---
 rtl/stack_ptr_guarded.sv | 102 ++++++++++
 tb/tb_stack_ptr_guarded.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ptr_guarded.sv
// Bounds-checked stack pointer with shadow register and sticky error flags.
// Latency: single cycle; every command takes effect on the sampling edge, and AT_LO/AT_HI are combinational.
// Backpressure: none; a strobe is applied on every cycle in which it is asserted.
module stack_ptr_guarded #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] LIMIT_LO  = '0,
    parameter logic [WIDTH-1:0] LIMIT_HI  = '1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               WRAP      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             LD,
    input  logic             INCR,
    input  logic             DECR,
    input  logic             SAVE,
    input  logic             RESTORE,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] D_OUT,
    output logic             AT_LO,
    output logic             AT_HI,
    output logic             OVF,
    output logic             UNF,
    output logic             BAD_LD
);

    // Number of legal addresses. One extra bit holds the full-range case 2**WIDTH.
    localparam logic [WIDTH:0] SPAN = {1'b0, LIMIT_HI} - {1'b0, LIMIT_LO} + (WIDTH+1)'(1);

    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             bad_q, bad_d;

    // Window test as an offset from LIMIT_LO, which avoids a
    // constant ">= 0" comparison when the window starts at address zero.
    function automatic logic in_win(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] off;
        off = v - LIMIT_LO;
        return ({1'b0, off} < SPAN);
    endfunction

    assign D_OUT  = ptr_q;
    assign AT_LO  = (ptr_q == LIMIT_LO);
    assign AT_HI  = (ptr_q == LIMIT_HI);
    assign OVF    = ovf_q;
    assign UNF    = unf_q;
    assign BAD_LD = bad_q;

    // Next pointer, shadow and flags. ERR_CLR clears first so that a new event in the same cycle wins.
    always_comb begin
        ptr_d    = ptr_q;
        shadow_d = SAVE ? ptr_q : shadow_q;
        ovf_d    = ovf_q & ~ERR_CLR;
        unf_d    = unf_q & ~ERR_CLR;
        bad_d    = bad_q & ~ERR_CLR;

        if (LD) begin
            // Out-of-window values are loaded as-is and only flagged.
            ptr_d = D_IN;
            if (!in_win(D_IN)) bad_d = 1'b1;
        end else if (RESTORE) begin
            // Reads the pre-edge shadow, so SAVE+RESTORE swaps the two registers.
            ptr_d = shadow_q;
            if (!in_win(shadow_q)) bad_d = 1'b1;
        end else if (INCR && !DECR) begin
            if (AT_HI) begin
                unf_d = 1'b1;
                if (WRAP) ptr_d = LIMIT_LO;
            end else begin
                ptr_d = ptr_q + WIDTH'(1);
            end
        end else if (DECR && !INCR) begin
            if (AT_LO) begin
                ovf_d = 1'b1;
                if (WRAP) ptr_d = LIMIT_HI;
            end else begin
                ptr_d = ptr_q - WIDTH'(1);
            end
        end
    end

    // State registers with synchronous active-high reset overriding every command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q    <= RESET_VAL;
            shadow_q <= RESET_VAL;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            bad_q    <= bad_d;
        end
    end

endmodule

// File: tb/tb_stack_ptr_guarded.sv
// Bench for stack_ptr_guarded: three parameterisations share one stimulus stream.
// Directed scenarios check fixed constants. A random phase checks each DUT against an arithmetic reference model.
module tb_stack_ptr_guarded;

    logic       CLK = 1'b0;
    logic       rst, ld, incr, decr, save, restore, err_clr;
    logic [7:0] din;

    always #5 CLK = ~CLK;

    // A: default parameters. B: saturating window 0x10..0x1F. C: 6-bit wrapping window 5..40 with an out-of-window reset value.
    logic [7:0] dout_a, dout_b;
    logic [5:0] dout_c;
    logic at_lo_a, at_hi_a, ovf_a, unf_a, bad_a;
    logic at_lo_b, at_hi_b, ovf_b, unf_b, bad_b;
    logic at_lo_c, at_hi_c, ovf_c, unf_c, bad_c;

    stack_ptr_guarded u_a (
        .CLK(CLK), .RST(rst), .D_IN(din), .LD(ld), .INCR(incr), .DECR(decr),
        .SAVE(save), .RESTORE(restore), .ERR_CLR(err_clr),
        .D_OUT(dout_a), .AT_LO(at_lo_a), .AT_HI(at_hi_a), .OVF(ovf_a), .UNF(unf_a), .BAD_LD(bad_a)
    );

    stack_ptr_guarded #(.WIDTH(8), .LIMIT_LO(8'h10), .LIMIT_HI(8'h1F), .RESET_VAL(8'h1F), .WRAP(1'b0)) u_b (
        .CLK(CLK), .RST(rst), .D_IN(din), .LD(ld), .INCR(incr), .DECR(decr),
        .SAVE(save), .RESTORE(restore), .ERR_CLR(err_clr),
        .D_OUT(dout_b), .AT_LO(at_lo_b), .AT_HI(at_hi_b), .OVF(ovf_b), .UNF(unf_b), .BAD_LD(bad_b)
    );

    stack_ptr_guarded #(.WIDTH(6), .LIMIT_LO(6'd5), .LIMIT_HI(6'd40), .RESET_VAL(6'd50), .WRAP(1'b1)) u_c (
        .CLK(CLK), .RST(rst), .D_IN(din[5:0]), .LD(ld), .INCR(incr), .DECR(decr),
        .SAVE(save), .RESTORE(restore), .ERR_CLR(err_clr),
        .D_OUT(dout_c), .AT_LO(at_lo_c), .AT_HI(at_hi_c), .OVF(ovf_c), .UNF(unf_c), .BAD_LD(bad_c)
    );

    // Reference model configuration and state, one slot per DUT.
    int cw[3]   = '{8, 8, 6};
    int clo[3]  = '{0, 16, 5};
    int chi[3]  = '{255, 31, 40};
    int crv[3]  = '{0, 31, 50};
    int cwr[3]  = '{1, 0, 1};
    int m_ptr[3], m_sh[3], m_ovf[3], m_unf[3], m_bad[3];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int k, input int v);
        return (v >= clo[k]) && (v <= chi[k]);
    endfunction

    // One clock edge of stack behaviour, written directly from the command rules.
    task automatic model_step(input int k);
        int modv, old_p, old_s, d;
        modv  = 1 << cw[k];
        d     = int'(din) % modv;
        old_p = m_ptr[k];
        old_s = m_sh[k];
        if (rst) begin
            m_ptr[k] = crv[k]; m_sh[k] = crv[k];
            m_ovf[k] = 0; m_unf[k] = 0; m_bad[k] = 0;
            return;
        end
        if (err_clr) begin
            m_ovf[k] = 0; m_unf[k] = 0; m_bad[k] = 0;
        end
        if (ld) begin
            m_ptr[k] = d;
            if (!legal(k, d)) m_bad[k] = 1;
        end else if (restore) begin
            m_ptr[k] = old_s;
            if (!legal(k, old_s)) m_bad[k] = 1;
        end else if (incr && !decr) begin
            if (old_p == chi[k]) begin
                m_unf[k] = 1;
                if (cwr[k] != 0) m_ptr[k] = clo[k];
            end else m_ptr[k] = (old_p + 1) % modv;
        end else if (decr && !incr) begin
            if (old_p == clo[k]) begin
                m_ovf[k] = 1;
                if (cwr[k] != 0) m_ptr[k] = chi[k];
            end else m_ptr[k] = (old_p - 1 + modv) % modv;
        end
        if (save) m_sh[k] = old_p;
    endtask

    function automatic int exp_pack(input int k);
        return (m_bad[k] << 12) | (m_unf[k] << 11) | (m_ovf[k] << 10)
             | (int'(m_ptr[k] == chi[k]) << 9) | (int'(m_ptr[k] == clo[k]) << 8) | m_ptr[k];
    endfunction

    function automatic int obs_pack(input int k);
        case (k)
            0: return (int'(bad_a) << 12) | (int'(unf_a) << 11) | (int'(ovf_a) << 10)
                    | (int'(at_hi_a) << 9) | (int'(at_lo_a) << 8) | int'(dout_a);
            1: return (int'(bad_b) << 12) | (int'(unf_b) << 11) | (int'(ovf_b) << 10)
                    | (int'(at_hi_b) << 9) | (int'(at_lo_b) << 8) | int'(dout_b);
            default: return (int'(bad_c) << 12) | (int'(unf_c) << 11) | (int'(ovf_c) << 10)
                    | (int'(at_hi_c) << 9) | (int'(at_lo_c) << 8) | int'(dout_c);
        endcase
    endfunction

    // Drive one cycle of commands, advance the models on the edge, then compare all DUTs.
    task automatic cyc(input bit i_rst, input bit i_ld, input bit i_res, input bit i_sav,
                       input bit i_inc, input bit i_dec, input bit i_clr, input logic [7:0] d);
        rst = i_rst; ld = i_ld; restore = i_res; save = i_sav;
        incr = i_inc; decr = i_dec; err_clr = i_clr; din = d;
        @(posedge CLK);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        chk("model_a", obs_pack(0), exp_pack(0));
        chk("model_b", obs_pack(1), exp_pack(1));
        chk("model_c", obs_pack(2), exp_pack(2));
    endtask

    // Short wrappers: rst ld res sav inc dec clr din
    task automatic do_rst();        cyc(1,0,0,0,0,0,0,8'h00); endtask
    task automatic do_ld(input logic [7:0] d); cyc(0,1,0,0,0,0,0,d); endtask
    task automatic do_inc();        cyc(0,0,0,0,1,0,0,8'h00); endtask
    task automatic do_dec();        cyc(0,0,0,0,0,1,0,8'h00); endtask
    task automatic do_clr();        cyc(0,0,0,0,0,0,1,8'h00); endtask

    logic [7:0] pick_tab [8] = '{8'h10, 8'h1F, 8'h0F, 8'h20, 8'h00, 8'hFF, 8'h05, 8'h28};

    initial begin
        rst = 1'b0; ld = 1'b0; incr = 1'b0; decr = 1'b0;
        save = 1'b0; restore = 1'b0; err_clr = 1'b0; din = 8'h00;
        for (int k = 0; k < 3; k++) begin
            m_ptr[k] = 0; m_sh[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_bad[k] = 0;
        end

        // Reset state
        do_rst();
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_dout_b", dout_b, 8'h1F);
        chk("rst_athi_b", at_hi_b, 1);
        chk("rst_dout_c", dout_c, 50);

        // Default push/pop with wrap
        do_dec(); do_dec(); do_dec();
        chk("s1_dec3_dout", dout_a, 8'hFD);
        chk("s1_dec3_ovf", ovf_a, 1);
        do_clr();
        chk("s1_clr_ovf", ovf_a, 0);
        do_inc(); do_inc(); do_inc();
        chk("s1_inc3_dout", dout_a, 8'h00);
        chk("s1_inc3_unf", unf_a, 1);

        // Saturating window
        do_rst();
        for (int i = 0; i < 15; i++) do_dec();
        chk("s2_dout_lo", dout_b, 8'h10);
        chk("s2_atlo", at_lo_b, 1);
        chk("s2_ovf_pre", ovf_b, 0);
        do_dec();
        chk("s2_sat_dout", dout_b, 8'h10);
        chk("s2_sat_ovf", ovf_b, 1);
        do_ld(8'h1F);
        do_inc();
        chk("s2_hi_dout", dout_b, 8'h1F);
        chk("s2_hi_unf", unf_b, 1);

        // Bad load keeps the value and stays flagged until cleared
        do_clr();
        do_ld(8'h40);
        chk("s3_bad_dout", dout_b, 8'h40);
        chk("s3_bad_flag", bad_b, 1);
        do_ld(8'h15);
        chk("s3_ok_dout", dout_b, 8'h15);
        chk("s3_sticky", bad_b, 1);
        do_clr();
        chk("s3_cleared", bad_b, 0);

        // Interrupt save/restore
        do_ld(8'h80);
        cyc(0,0,0,1,0,1,0,8'h00);
        chk("s4_savedec", dout_a, 8'h7F);
        do_dec(); do_dec();
        chk("s4_dec2", dout_a, 8'h7D);
        cyc(0,0,1,0,0,0,0,8'h00);
        chk("s4_restore", dout_a, 8'h80);
        do_ld(8'h33);
        cyc(0,0,1,1,0,0,0,8'h00);
        chk("s4_swap_dout", dout_a, 8'h80);
        cyc(0,0,1,0,0,0,0,8'h00);
        chk("s4_swap_shadow", dout_a, 8'h33);

        // Priority and simultaneity
        cyc(0,1,0,0,1,1,0,8'h22);
        chk("s5_ld_wins", dout_a, 8'h22);
        cyc(0,1,0,0,0,0,1,8'hFF);
        cyc(0,0,0,0,1,1,0,8'h00);
        chk("s5_net0_dout", dout_a, 8'hFF);
        chk("s5_net0_unf", unf_a, 0);
        do_ld(8'h00);
        cyc(0,0,0,0,0,1,1,8'h00);
        chk("s5_clr_vs_ovf", ovf_a, 1);

        // Reset in the middle of activity, with a load that must be ignored
        do_ld(8'h55);
        cyc(0,1,0,1,0,0,0,8'h9A);
        chk("s6_pre_dout", dout_a, 8'h9A);
        chk("s6_pre_ovf", ovf_a, 1);
        cyc(1,1,0,0,0,0,0,8'h77);
        chk("s6_rst_dout", dout_a, 8'h00);
        chk("s6_rst_ovf", ovf_a, 0);
        cyc(0,0,1,0,0,0,0,8'h00);
        chk("s6_rst_shadow", dout_a, 8'h00);

        // Randomised commands against the reference models
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? pick_tab[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
